// File: rtl/ex_muldiv_pkg.sv
// Shared types and op-classification helpers for the EX-stage multiply/divide unit.
// The decoder produces Muldiv_op_t; ex_muldiv turns unknown encodings into MD_MULTU.
package ex_muldiv_pkg;

  localparam int XLEN = 32;

  typedef logic [2*XLEN-1:0] Doubleword_t;

  typedef enum logic [3:0] {
    MD_MULT  = 4'd0,
    MD_MULTU = 4'd1,
    MD_DIV   = 4'd2,
    MD_DIVU  = 4'd3,
    MD_MADD  = 4'd4,
    MD_MADDU = 4'd5,
    MD_MSUB  = 4'd6,
    MD_MSUBU = 4'd7
  } Muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } Muldiv_state_t;

  // Encodings outside the enum fall back to an unsigned multiply so no X escapes.
  function automatic Muldiv_op_t decode_op(input logic [3:0] raw);
    case (raw)
      4'd0:    return MD_MULT;
      4'd2:    return MD_DIV;
      4'd3:    return MD_DIVU;
      4'd4:    return MD_MADD;
      4'd5:    return MD_MADDU;
      4'd6:    return MD_MSUB;
      4'd7:    return MD_MSUBU;
      default: return MD_MULTU;
    endcase
  endfunction

  function automatic logic is_div_op(input Muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_md(input Muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

  function automatic logic is_acc_md(input Muldiv_op_t op);
    return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

  function automatic logic is_sub_md(input Muldiv_op_t op);
    return (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

endpackage

// File: rtl/ex_muldiv_div_step.sv
// One iteration of restoring division: shifts DIV_BITS dividend bits into the
// partial remainder and retires the matching quotient bits into the dividend register.
module muldiv_div_step
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DIV_BITS = 1
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] dvd_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] dvd_out
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;

  // The remainder stays below the divisor, so the trial value always fits in WIDTH+1 bits.
  always_comb begin
    rem   = rem_in;
    dvd   = dvd_in;
    trial = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      trial = {rem, dvd[WIDTH-1]};
      dvd   = {dvd[WIDTH-2:0], 1'b0};
      if (trial >= {1'b0, divisor}) begin
        trial  = trial - {1'b0, divisor};
        dvd[0] = 1'b1;
      end
      rem = trial[WIDTH-1:0];
    end
    rem_out = rem;
    dvd_out = dvd;
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle multiply / divide / multiply-accumulate unit for EX. Holds the pipeline
// via stallreq and pulses done for one cycle while hi_o/lo_o carry the result.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [2*WIDTH-1:0] hilo_in,
  input  logic               flush,
  output logic               stallreq,
  output logic               done,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  localparam int DIV_CYCLES = WIDTH / DIV_BITS;
  localparam int CNT_MAX    = (DIV_CYCLES > MUL_STAGES) ? DIV_CYCLES : MUL_STAGES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STAGES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  Muldiv_state_t state, next_state;
  Muldiv_op_t    op_d, op_q;

  logic               sgn_d, accept, stall_raw, div_zero;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   mag_a, mag_b, rem_q, dvd_q, rem_nx, dvd_nx;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] hilo_q, prod, sprod, mul_comb, mul_tap;
  logic               neg_q, sign_a_q;
  logic [CNT_W-1:0]   cnt;

  assign op_d     = decode_op(op);
  assign sgn_d    = is_signed_md(op_d);
  assign abs_a    = (sgn_d && src_a[WIDTH-1]) ? -src_a : src_a;
  assign abs_b    = (sgn_d && src_b[WIDTH-1]) ? -src_b : src_b;
  assign div_zero = is_div_op(op_d) && (src_b == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    stall_raw  = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    if (flush) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          accept    = 1'b1;
          stall_raw = 1'b1;
          if (div_zero)               next_state = ST_DONE;
          else if (is_div_op(op_d))   next_state = ST_DIV;
          else                        next_state = ST_MUL;
        end
        ST_MUL: begin
          stall_raw = 1'b1;
          if (cnt == MUL_LAST) next_state = ST_DONE;
        end
        ST_DIV: begin
          stall_raw = 1'b1;
          if (cnt == DIV_LAST) next_state = ST_FIX;
        end
        ST_FIX: begin
          stall_raw  = 1'b1;
          next_state = ST_DONE;
        end
        ST_DONE: begin
          done       = 1'b1;
          next_state = ST_IDLE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // A start held across reset must not stall the pipeline while the unit is held in reset.
  assign stallreq = stall_raw & rst;

  assign prod  = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
  assign sprod = neg_q ? -prod : prod;

  always_comb begin
    mul_comb = sprod;
    if (is_acc_md(op_q)) mul_comb = is_sub_md(op_q) ? (hilo_q - sprod) : (hilo_q + sprod);
  end

  // The final result register is the last multiplier stage; earlier stages live here.
  generate
    if (MUL_STAGES == 1) begin : g_mul_one
      assign mul_tap = mul_comb;
    end else begin : g_mul_pipe
      logic [2*WIDTH-1:0] pipe [MUL_STAGES-1];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < MUL_STAGES - 1; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= mul_comb;
          for (int i = 1; i < MUL_STAGES - 1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign mul_tap = pipe[MUL_STAGES-2];
    end
  endgenerate

  muldiv_div_step #(.WIDTH(WIDTH), .DIV_BITS(DIV_BITS)) u_div_step (
    .rem_in  (rem_q),
    .dvd_in  (dvd_q),
    .divisor (mag_b),
    .rem_out (rem_nx),
    .dvd_out (dvd_nx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= MD_MULT;
      hilo_q   <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      cnt      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (accept) begin
        op_q     <= op_d;
        hilo_q   <= hilo_in;
        mag_a    <= abs_a;
        mag_b    <= abs_b;
        dvd_q    <= abs_a;
        rem_q    <= '0;
        neg_q    <= sgn_d & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        sign_a_q <= sgn_d & src_a[WIDTH-1];
        cnt      <= '0;
        if (div_zero) begin
          hi_q <= src_a;
          lo_q <= '1;
        end
      end
      if (state == ST_MUL || state == ST_DIV) cnt <= cnt + CNT_W'(1);
      if (state == ST_DIV) begin
        rem_q <= rem_nx;
        dvd_q <= dvd_nx;
      end
      if (!flush && state == ST_MUL && cnt == MUL_LAST) {hi_q, lo_q} <= mul_tap;
      // Quotient sign follows the operand signs; remainder takes the dividend's sign.
      if (!flush && state == ST_FIX) begin
        lo_q <= neg_q ? -dvd_q : dvd_q;
        hi_q <= sign_a_q ? -rem_q : rem_q;
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, stall profile and {hi, lo} results for each op
// class, plus divide-by-zero, signed wrap cases, flush and mid-operation reset.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  Doubleword_t hilo_in;
  logic        flush;
  logic        stallreq;
  logic        done;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int errors = 0;
  int checks = 0;

  ex_muldiv #(.WIDTH(32), .MUL_STAGES(2), .DIV_BITS(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .hilo_in  (hilo_in),
    .flush    (flush),
    .stallreq (stallreq),
    .done     (done),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=no end expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; start is held through the done cycle, then dropped.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] hl, input int lat,
                        input logic [63:0] exp);
    int c;
    bit seen;
    bit stall_ok;
    op = o; src_a = a; src_b = b; hilo_in = hl; start = 1'b1;
    c = 0; seen = 1'b0; stall_ok = 1'b1;
    while (!seen && c <= 100) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        if (!stallreq) stall_ok = 1'b0;
        c++;
        @(posedge clk); #1;
      end
    end
    chk({tag, "_latency"}, 64'(c), 64'(lat));
    chk({tag, "_result"}, {hi_o, lo_o}, exp);
    chk({tag, "_stall_on_done"}, {63'd0, stallreq}, 64'd0);
    chk({tag, "_stall_before_done"}, {63'd0, stall_ok}, 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_after_done"}, {62'd0, done, stallreq}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    bit quiet;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0; hilo_in = '0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_hi", {32'd0, hi_o}, 64'd0);
    chk("reset_lo", {32'd0, lo_o}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_stall", {63'd0, stallreq}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_op("mult_neg2x3", 4'd0, 32'hFFFF_FFFE, 32'd3, 64'd0, 3, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("divu_100_7", 4'd3, 32'd100, 32'd7, 64'd0, 34, {32'd2, 32'd14});
    run_op("div_m7_2", 4'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, 34, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("madd_5_2x3", 4'd4, 32'd2, 32'd3, 64'd5, 3, 64'd11);
    run_op("msubu_0_1x1", 4'd7, 32'd1, 32'd1, 64'd0, 3, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("div_by_zero", 4'd2, 32'h0000_1234, 32'd0, 64'd0, 1, {32'h0000_1234, 32'hFFFF_FFFF});
    run_op("divu_by_zero", 4'd3, 32'h0000_DEAD, 32'd0, 64'd0, 1, {32'h0000_DEAD, 32'hFFFF_FFFF});
    run_op("div_min_m1", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 34, {32'd0, 32'h8000_0000});
    run_op("mult_min_min", 4'd0, 32'h8000_0000, 32'h8000_0000, 64'd0, 3, 64'h4000_0000_0000_0000);
    run_op("op_undef_multu", 4'hF, 32'hFFFF_FFFF, 32'd2, 64'd0, 3, 64'h0000_0001_FFFF_FFFE);
    run_op("msub_10_m3x4", 4'd6, 32'hFFFF_FFFD, 32'd4, 64'd10, 3, 64'd22);
    run_op("maddu_wrap", 4'd5, 32'd2, 32'd3, 64'hFFFF_FFFF_FFFF_FFFF, 3, 64'd5);
    run_op("divu_big", 4'd3, 32'hFFFF_FFFF, 32'h10, 64'd0, 34, {32'h0000_000F, 32'h0FFF_FFFF});
    run_op("div_7_m2", 4'd2, 32'd7, 32'hFFFF_FFFE, 64'd0, 34, {32'd1, 32'hFFFF_FFFD});

    // Flush ten cycles into a divide, with start still high in the flush cycle.
    op = 4'd3; src_a = 32'd100; src_b = 32'd7; hilo_in = '0; start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", {63'd0, stallreq}, 64'd0);
    chk("flush_done", {63'd0, done}, 64'd0);
    chk("flush_hold_result", {hi_o, lo_o}, {32'd1, 32'hFFFF_FFFD});
    @(posedge clk); #1;
    flush = 1'b0;
    run_op("multu_after_flush", 4'd1, 32'd5, 32'd6, 64'd0, 3, 64'd30);

    // flush together with start in IDLE must not accept anything.
    op = 4'd0; src_a = 32'd3; src_b = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_stall", {63'd0, stallreq}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done || stallreq) quiet = 1'b0;
      @(posedge clk); #1;
    end
    chk("idle_flush_no_accept", {63'd0, quiet}, 64'd1);
    chk("idle_flush_hold_result", {hi_o, lo_o}, 64'd30);

    // Reset in the middle of a divide; the held start is then accepted afresh.
    op = 4'd3; src_a = 32'd100; src_b = 32'd7; hilo_in = '0; start = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("midrst_hi", {32'd0, hi_o}, 64'd0);
    chk("midrst_lo", {32'd0, lo_o}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_stall", {63'd0, stallreq}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_op("divu_after_rst", 4'd3, 32'd100, 32'd7, 64'd0, 34, {32'd2, 32'd14});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
